// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
package fifo_pkg;

    // Default geometry and watermark levels.
    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultAddrW = 3;
    localparam int unsigned DefaultAfLvl = 6;
    localparam int unsigned DefaultAeLvl = 2;

    // Read-side mode encoding for the FWFT parameter.
    localparam int unsigned FwftRegistered  = 0;
    localparam int unsigned FwftFallThrough = 1;

    // Accepted operation on one clock edge, {push, pop}.
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, status-flag and sticky-error logic for the FIFO.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned AF_LVL = DefaultAfLvl,
    parameter int unsigned AE_LVL = DefaultAeLvl
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wen_i,
    input  logic              ren_i,
    input  logic              clr_err_i,
    output logic              push_o,
    output logic              pop_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [ADDR_W-1:0] raddr_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int unsigned PtrW = ADDR_W + 1;
    localparam logic [ADDR_W:0] PtrOne = PtrW'(1);
    localparam logic [ADDR_W:0] AfLvl  = PtrW'(AF_LVL);
    localparam logic [ADDR_W:0] AeLvl  = PtrW'(AE_LVL);

    // Pointers carry one extra wrap bit above the memory index.
    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    fifo_op_e        op;

    // Status flags come straight from the registered pointers.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                     (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

    // Acceptance uses pre-edge full/empty; reset suppresses both sides.
    assign push_o = wen_i && !full_o && !rst_i;
    assign pop_o  = ren_i && !empty_o && !rst_i;

    assign waddr_o = wptr_q[ADDR_W-1:0];
    assign raddr_o = rptr_q[ADDR_W-1:0];

    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= AfLvl);
    assign almost_empty_o = (count_q <= AeLvl);

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        op          = fifo_op(push_o, pop_o);

        unique case (op)
            OpPush: begin
                wptr_d  = wptr_q + PtrOne;
                count_d = count_q + PtrOne;
            end
            OpPop: begin
                rptr_d  = rptr_q + PtrOne;
                count_d = count_q - PtrOne;
            end
            OpBoth: begin
                wptr_d = wptr_q + PtrOne;
                rptr_d = rptr_q + PtrOne;
            end
            default: begin
            end
        endcase

        // A fresh error on the clearing edge wins over the clear.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wen_i && full_o) begin
            overflow_d = 1'b1;
        end
        if (ren_i && empty_o) begin
            underflow_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or first-word-fall-through read port.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ADDR_W = DefaultAddrW,
    parameter int unsigned AF_LVL = DefaultAfLvl,
    parameter int unsigned AE_LVL = DefaultAeLvl,
    parameter int unsigned FWFT   = FwftRegistered
) (
    input  logic              clk_single_domain,
    input  logic              rst,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;

    // Storage is deliberately not reset; stale words are unreachable after rst.
    logic [DATA_W-1:0] mem_q [Depth];

    fifo_ptr_ctrl #(
        .ADDR_W (ADDR_W),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) u_ptr_ctrl (
        .clk_i          (clk_single_domain),
        .rst_i          (rst),
        .wen_i          (wen),
        .ren_i          (ren),
        .clr_err_i      (clr_err),
        .push_o         (push),
        .pop_o          (pop),
        .waddr_o        (waddr),
        .raddr_o        (raddr),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .count_o        (count),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    // Write the accepted push into the slot addressed by the write pointer.
    always_ff @(posedge clk_single_domain) begin
        if (push) begin
            mem_q[waddr] <= wdata;
        end
    end

    if (FWFT == FwftFallThrough) begin : g_fwft
        // Head word is shown combinationally; ren only acknowledges it.
        assign rvalid = !empty;
        assign rdata  = empty ? '0 : mem_q[raddr];
    end else begin : g_registered
        logic [DATA_W-1:0] rdata_q, rdata_d;
        logic              rvalid_q, rvalid_d;

        // Capture the head word only on an accepted pop, else zero.
        always_comb begin
            rvalid_d = pop;
            rdata_d  = '0;
            if (pop) begin
                rdata_d = mem_q[raddr];
            end
        end

        // Read-data register with synchronous active-high reset.
        always_ff @(posedge clk_single_domain) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: registered and fall-through instances share stimulus
// and are compared against a queue-based model of the FIFO rules.
module tb_sync_fifo_param;

    localparam int DEPTH = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata_0, rdata_1;
    logic       rvalid_0, rvalid_1;
    logic       full_0, full_1, empty_0, empty_1;
    logic       af_0, af_1, ae_0, ae_1;
    logic [3:0] count_0, count_1;
    logic       ovf_0, ovf_1, unf_0, unf_1;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] q[$];
    bit         m_ovf, m_unf, m_v0;
    logic [7:0] m_d0;

    always #5 clk = ~clk;

    sync_fifo_param #(.FWFT(0)) u_dut_reg (
        .clk_single_domain (clk), .rst (rst), .wen (wen), .wdata (wdata), .ren (ren),
        .clr_err (clr_err), .rdata (rdata_0), .rvalid (rvalid_0), .full (full_0),
        .empty (empty_0), .almost_full (af_0), .almost_empty (ae_0), .count (count_0),
        .overflow (ovf_0), .underflow (unf_0)
    );

    sync_fifo_param #(.FWFT(1)) u_dut_fwft (
        .clk_single_domain (clk), .rst (rst), .wen (wen), .wdata (wdata), .ren (ren),
        .clr_err (clr_err), .rdata (rdata_1), .rvalid (rvalid_1), .full (full_1),
        .empty (empty_1), .almost_full (af_1), .almost_empty (ae_1), .count (count_1),
        .overflow (ovf_1), .underflow (unf_1)
    );

    // Drive one cycle of inputs, advance the model at the edge, then idle inputs.
    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c,
                        input bit rs);
        bit was_full;
        bit was_empty;
        wen = w; wdata = d; ren = r; clr_err = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_v0 = 0; m_d0 = 8'h00;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (w && was_full) m_ovf = 1; else if (c) m_ovf = 0;
            if (r && was_empty) m_unf = 1; else if (c) m_unf = 0;
            if (r && !was_empty) begin
                m_d0 = q.pop_front();
                m_v0 = 1;
            end else begin
                m_d0 = 8'h00;
                m_v0 = 0;
            end
            if (w && !was_full) q.push_back(d);
        end
        #1;
        wen = 1'b0; ren = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 8'h5A, 1, 0, 1);
        checks++; if (count_0 !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_0); end
        checks++; if (empty_0 !== 1'b1 || ae_0 !== 1'b1) begin errors++; $display("FAIL reset_empty got %b/%b exp 1/1", empty_0, ae_0); end
        checks++; if (full_0 !== 1'b0 || af_0 !== 1'b0) begin errors++; $display("FAIL reset_full got %b/%b exp 0/0", full_0, af_0); end
        checks++; if (ovf_0 !== 1'b0 || unf_0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b/%b exp 0/0", ovf_0, unf_0); end
        checks++; if (rvalid_0 !== 1'b0 || rdata_0 !== 8'h00) begin errors++; $display("FAIL reset_rd_reg got %b/%h exp 0/00", rvalid_0, rdata_0); end
        checks++; if (rvalid_1 !== 1'b0 || rdata_1 !== 8'h00) begin errors++; $display("FAIL reset_rd_fwft got %b/%h exp 0/00", rvalid_1, rdata_1); end
    endtask

    task automatic test_fill();
        logic [7:0] dv;
        for (int i = 0; i < DEPTH; i++) begin
            dv = 8'((i + 1) * 17);
            step(1, dv, 0, 0, 0);
            checks++; if (count_0 !== 4'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count_0, i + 1); end
            checks++; if (af_0 !== ((i + 1) >= AF)) begin errors++; $display("FAIL fill_af at %0d got %b", i + 1, af_0); end
            checks++; if (full_0 !== (i == DEPTH - 1)) begin errors++; $display("FAIL fill_full at %0d got %b", i + 1, full_0); end
        end
        step(1, 8'hEE, 0, 0, 0);
        checks++; if (ovf_0 !== 1'b1 || ovf_1 !== 1'b1) begin errors++; $display("FAIL overflow got %b/%b exp 1/1", ovf_0, ovf_1); end
        checks++; if (count_0 !== 4'd8) begin errors++; $display("FAIL overflow_count got %0d exp 8", count_0); end
    endtask

    task automatic test_drain();
        logic [7:0] dv;
        logic [7:0] head;
        for (int i = 0; i < DEPTH; i++) begin
            dv = 8'((i + 1) * 17);
            step(0, 8'h00, 1, 0, 0);
            checks++; if (rvalid_0 !== 1'b1 || rdata_0 !== dv) begin errors++; $display("FAIL drain_data got %b/%h exp 1/%h", rvalid_0, rdata_0, dv); end
            head = (q.size() != 0) ? q[0] : 8'h00;
            checks++; if (rdata_1 !== head) begin errors++; $display("FAIL drain_fwft got %h exp %h", rdata_1, head); end
        end
        checks++; if (empty_0 !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty_0); end
        step(0, 8'h00, 1, 0, 0);
        checks++; if (unf_0 !== 1'b1 || rvalid_0 !== 1'b0) begin errors++; $display("FAIL underflow got %b/%b exp 1/0", unf_0, rvalid_0); end
        checks++; if (ovf_0 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf_0); end
        step(0, 8'h00, 0, 1, 0);
        checks++; if (ovf_0 !== 1'b0 || unf_0 !== 1'b0) begin errors++; $display("FAIL clr_err got %b/%b exp 0/0", ovf_0, unf_0); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] first;
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0, 0);
        first = q[0];
        step(1, 8'h77, 1, 0, 0);
        checks++; if (count_0 !== 4'd7 || ovf_0 !== 1'b1) begin errors++; $display("FAIL full_both got %0d/%b exp 7/1", count_0, ovf_0); end
        checks++; if (rvalid_0 !== 1'b1 || rdata_0 !== first) begin errors++; $display("FAIL full_both_data got %b/%h exp 1/%h", rvalid_0, rdata_0, first); end
        for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(1, 8'h3C, 1, 0, 0);
        checks++; if (count_0 !== 4'd1 || unf_0 !== 1'b1 || rvalid_0 !== 1'b0) begin errors++; $display("FAIL empty_both got %0d/%b/%b exp 1/1/0", count_0, unf_0, rvalid_0); end
        checks++; if (rvalid_1 !== 1'b1 || rdata_1 !== 8'h3C) begin errors++; $display("FAIL empty_both_fwft got %b/%h exp 1/3c", rvalid_1, rdata_1); end
    endtask

    task automatic test_wrap();
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'($urandom), 1, 0, 0);
            checks++; if (count_0 !== 4'd4 || count_1 !== 4'd4) begin errors++; $display("FAIL wrap_count got %0d/%0d exp 4", count_0, count_1); end
            checks++; if (rvalid_0 !== 1'b1 || rdata_0 !== m_d0) begin errors++; $display("FAIL wrap_data got %b/%h exp 1/%h", rvalid_0, rdata_0, m_d0); end
            checks++; if ({full_0, empty_0, ovf_0, unf_0} !== 4'b0000) begin errors++; $display("FAIL wrap_flags got %b exp 0000", {full_0, empty_0, ovf_0, unf_0}); end
        end
    endtask

    task automatic test_fwft();
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'hA5, 0, 0, 0);
        checks++; if (rvalid_1 !== 1'b1 || rdata_1 !== 8'hA5) begin errors++; $display("FAIL fwft_show got %b/%h exp 1/a5", rvalid_1, rdata_1); end
        checks++; if (rvalid_0 !== 1'b0) begin errors++; $display("FAIL reg_no_pop got %b exp 0", rvalid_0); end
        step(0, 8'h00, 0, 0, 0);
        checks++; if (rvalid_1 !== 1'b1 || rdata_1 !== 8'hA5) begin errors++; $display("FAIL fwft_hold got %b/%h exp 1/a5", rvalid_1, rdata_1); end
        step(0, 8'h00, 1, 0, 0);
        checks++; if (rvalid_1 !== 1'b0 || rdata_1 !== 8'h00) begin errors++; $display("FAIL fwft_ack got %b/%h exp 0/00", rvalid_1, rdata_1); end
        checks++; if (rvalid_0 !== 1'b1 || rdata_0 !== 8'hA5) begin errors++; $display("FAIL reg_pop got %b/%h exp 1/a5", rvalid_0, rdata_0); end
    endtask

    task automatic test_reset_mid();
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, 0);
        step(1, 8'h99, 0, 0, 1);
        checks++; if (count_0 !== 4'd0 || empty_0 !== 1'b1 || rvalid_0 !== 1'b0) begin errors++; $display("FAIL midrst got %0d/%b/%b exp 0/1/0", count_0, empty_0, rvalid_0); end
        checks++; if ({ovf_0, unf_0, af_0, full_0} !== 4'b0000 || ae_0 !== 1'b1) begin errors++; $display("FAIL midrst_flags got %b/%b", {ovf_0, unf_0, af_0, full_0}, ae_0); end
        step(0, 8'h00, 1, 0, 0);
        checks++; if (unf_0 !== 1'b1 || rvalid_0 !== 1'b0) begin errors++; $display("FAIL midrst_discard got %b/%b exp 1/0", unf_0, rvalid_0); end
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0, 0);
        step(1, 8'h42, 0, 1, 0);
        checks++; if (ovf_0 !== 1'b1 || unf_0 !== 1'b0) begin errors++; $display("FAIL clr_vs_err got %b/%b exp 1/0", ovf_0, unf_0); end
        step(0, 8'h00, 0, 1, 0);
        checks++; if (ovf_0 !== 1'b0) begin errors++; $display("FAIL clr_only got %b exp 0", ovf_0); end
    endtask

    task automatic test_random();
        bit w, r, c, rs;
        logic [7:0] head;
        for (int i = 0; i < 600; i++) begin
            // Alternate fill-biased and drain-biased phases to reach both ends.
            if (((i / 40) % 2) == 0) begin
                w = ($urandom_range(3) != 0); r = ($urandom_range(3) == 0);
            end else begin
                w = ($urandom_range(3) == 0); r = ($urandom_range(3) != 0);
            end
            c  = ($urandom_range(15) == 0);
            rs = ($urandom_range(127) == 0);
            step(w, 8'($urandom), r, c, rs);
            head = (q.size() != 0) ? q[0] : 8'h00;
            checks++; if (count_0 !== 4'(q.size()) || count_1 !== 4'(q.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d/%0d exp %0d", i, count_0, count_1, q.size()); end
            checks++; if (full_0 !== (q.size() == DEPTH) || empty_0 !== (q.size() == 0)) begin errors++; $display("FAIL rnd_fe cyc %0d got %b%b exp size %0d", i, full_0, empty_0, q.size()); end
            checks++; if (af_0 !== (q.size() >= AF) || ae_0 !== (q.size() <= AE)) begin errors++; $display("FAIL rnd_almost cyc %0d got %b%b exp size %0d", i, af_0, ae_0, q.size()); end
            checks++; if (ovf_0 !== m_ovf || unf_0 !== m_unf || ovf_1 !== m_ovf || unf_1 !== m_unf) begin errors++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", i, ovf_0, unf_0, m_ovf, m_unf); end
            checks++; if (rvalid_0 !== m_v0 || rdata_0 !== m_d0) begin errors++; $display("FAIL rnd_reg cyc %0d got %b/%h exp %b/%h", i, rvalid_0, rdata_0, m_v0, m_d0); end
            checks++; if (rvalid_1 !== (q.size() != 0) || rdata_1 !== head) begin errors++; $display("FAIL rnd_fwft cyc %0d got %b/%h exp %h", i, rvalid_1, rdata_1, head); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_fwft();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
